// File: rtl/debug_clk_en_sched_pkg.sv
`default_nettype none
// debug_clk_pkg: shared state type, defaults and sizing helper for the debug clock scheduler.
// Rev 1.0
package debug_clk_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_t;

  localparam int DIV_W_DEF = 8;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_clk_en_sched_if.sv
`default_nettype none
// debug_clk_en_sched_if: valid/ready config port carrying per-channel divide/enable updates.
// Rev 1.0
interface debug_clk_en_sched_if
  import debug_clk_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = DIV_W_DEF
);
  localparam int CH_W = ch_w(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             cfg_done;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready, cfg_done, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/debug_clk_en_sched_channel.sv
`default_nettype none
// debug_clk_en_channel: one divided-clock channel; period div_act+1, ce strobe and square wave.
// Rev 1.0
module debug_clk_en_channel #(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(1),
  parameter logic             RST_EN  = 1'b0
) (
  input  logic             clk_ref,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             load_en,
  output logic             term,
  output logic             en,
  output logic             ce,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;

  assign term = en && (cnt == div_act);

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_act <= RST_DIV;
      en      <= RST_EN;
      ce      <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      // The closing strobe/toggle of the old period still fires on a load edge.
      ce <= term;
      if (term) begin
        clk_out <= ~clk_out;
      end
      if (load) begin
        div_act <= load_div;
        en      <= load_en;
        cnt     <= '0;
      end else if (term || !en) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_clk_en_sched.sv
`default_nettype none
// debug_clk_en_sched: schedules NUM_CH divided debug clocks, applying config at period edges.
// Rev 1.0
module debug_clk_en_sched
  import debug_clk_pkg::*;
#(
  parameter int                NUM_CH  = 3,
  parameter int                DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0]  RST_DIV = DIV_W'(1),
  parameter logic [NUM_CH-1:0] RST_EN  = NUM_CH'(1)
) (
  input  logic                clk_ref,
  input  logic                rst_n,
  debug_clk_en_sched_if.slave cfg,
  output logic [NUM_CH-1:0]   ce,
  output logic [NUM_CH-1:0]   clk_out
);

  localparam int CH_W = ch_w(NUM_CH);

  cfg_state_t        state;
  logic [CH_W-1:0]   pend_ch;
  logic [DIV_W-1:0]  pend_div;
  logic              pend_en;
  logic              done_q;
  logic              err_q;

  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] load;
  logic              applied;

  assign cfg.cfg_ready = (state == IDLE);
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;

  assign load    = (state == APPLY) ? hit : '0;
  assign applied = |load;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Idle channel: apply at once. Disable: wait for the high phase to end. Else: next terminal.
      assign hit[i] = (pend_ch == CH_W'(i)) &&
                      (!ch_en[i] || (term[i] && (pend_en || clk_out[i])));

      debug_clk_en_channel #(
        .DIV_W   (DIV_W),
        .RST_DIV (RST_DIV),
        .RST_EN  (RST_EN[i])
      ) u_channel (
        .clk_ref  (clk_ref),
        .rst_n    (rst_n),
        .load     (load[i]),
        .load_div (pend_div),
        .load_en  (pend_en),
        .term     (term[i]),
        .en       (ch_en[i]),
        .ce       (ce[i]),
        .clk_out  (clk_out[i])
      );
    end
  endgenerate

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend_ch  <= '0;
      pend_div <= '0;
      pend_en  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            if (int'(cfg.cfg_ch) >= NUM_CH) begin
              err_q <= 1'b1;
            end else begin
              pend_ch  <= cfg.cfg_ch;
              pend_div <= cfg.cfg_div;
              pend_en  <= cfg.cfg_en;
              state    <= APPLY;
            end
          end
        end
        APPLY: begin
          if (applied) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_clk_en_sched.sv
`default_nettype none
// tb_debug_clk_en_sched: directed, cycle-exact checks of the debug clock scheduler.
// Rev 1.0
module tb_debug_clk_en_sched;

  logic       clk_ref;
  logic       rst_n;
  logic [2:0] ce;
  logic [2:0] clk_out;
  int         cyc;
  int         n_checks;
  int         n_fail;

  debug_clk_en_sched_if #(.NUM_CH(3), .DIV_W(8)) cfg_if ();

  debug_clk_en_sched #(
    .NUM_CH  (3),
    .DIV_W   (8),
    .RST_DIV (8'd1),
    .RST_EN  (3'b001)
  ) dut (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .cfg     (cfg_if.slave),
    .ce      (ce),
    .clk_out (clk_out)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_ref);
    cyc++;
  endtask

  // Drive one request in the current cycle; the upcoming edge accepts it.
  task automatic send(input logic [1:0] ch, input logic [7:0] div, input logic en);
    check("accept_ready", 32'(cfg_if.cfg_ready), 32'(1));
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_div   = div;
    cfg_if.cfg_en    = en;
    @(posedge clk_ref);
    #1;
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_en    = 1'b0;
    repeat (3) @(negedge clk_ref);

    // Reset release, defaults: ch0 div=1 enabled
    rst_n = 1'b1;
    cyc   = 0;
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'(1));
    check("rst_ce", 32'(ce), 32'(0));
    check("rst_clk", 32'(clk_out), 32'(0));
    check("rst_done", 32'(cfg_if.cfg_done), 32'(0));
    check("rst_err", 32'(cfg_if.cfg_err), 32'(0));
    for (int c = 1; c <= 7; c++) begin
      tick();
      check("t1_ce0", 32'(ce[0]), 32'(c >= 2 && c % 2 == 0));
      check("t1_clk0", 32'(clk_out[0]), 32'((c / 2) % 2 == 1));
      check("t1_ce12", 32'(ce[2:1]), 32'(0));
    end

    // Re-divide running ch0 to 3
    tick();
    check("t2_ce0_pre", 32'(ce[0]), 32'(1));
    send(2'd0, 8'd3, 1'b1);
    for (int c = 9; c <= 17; c++) begin
      tick();
      check("t2_ready", 32'(cfg_if.cfg_ready), 32'(c != 9));
      check("t2_done", 32'(cfg_if.cfg_done), 32'(c == 10));
      check("t2_ce0", 32'(ce[0]), 32'(c == 10 || c == 14));
      check("t2_clk0", 32'(clk_out[0]), 32'(c >= 10 && c <= 13));
    end

    // Enable idle ch1 with div=0
    send(2'd1, 8'd0, 1'b1);
    for (int c = 18; c <= 21; c++) begin
      tick();
      check("t3_ready", 32'(cfg_if.cfg_ready), 32'(c != 18));
      check("t3_done", 32'(cfg_if.cfg_done), 32'(c == 19));
      check("t3_ce0", 32'(ce[0]), 32'(c == 18));
      check("t3_clk0", 32'(clk_out[0]), 32'(1));
      if (c != 20) check("t3_ce1", 32'(ce[1]), 32'(c == 21));
      if (c == 21) check("t3_clk1", 32'(clk_out[1]), 32'(0));
    end

    // Disable ch0 while its clock is low: must wait for a full high phase
    tick();
    check("t4_clk0_pre", 32'(clk_out[0]), 32'(0));
    send(2'd0, 8'd3, 1'b0);
    for (int c = 23; c <= 33; c++) begin
      tick();
      check("t4_ready", 32'(cfg_if.cfg_ready), 32'(!(c >= 23 && c <= 29)));
      check("t4_done", 32'(cfg_if.cfg_done), 32'(c == 30));
      check("t4_ce0", 32'(ce[0]), 32'(c == 26 || c == 30));
      check("t4_clk0", 32'(clk_out[0]), 32'(c >= 26 && c <= 29));
      check("t4_ce1", 32'(ce[1]), 32'(1));
    end

    // Out-of-range channel
    tick();
    send(2'd3, 8'd5, 1'b1);
    for (int c = 35; c <= 37; c++) begin
      tick();
      check("t5_err", 32'(cfg_if.cfg_err), 32'(c == 35));
      check("t5_ready", 32'(cfg_if.cfg_ready), 32'(1));
      check("t5_done", 32'(cfg_if.cfg_done), 32'(0));
      check("t5_ch0", 32'({ce[0], clk_out[0]}), 32'(0));
      check("t5_ce1", 32'(ce[1]), 32'(1));
    end

    // Reset while a config is pending in APPLY
    tick();
    send(2'd0, 8'd7, 1'b1);
    tick();
    check("t6_apply_ready", 32'(cfg_if.cfg_ready), 32'(0));
    tick();
    check("t6_done", 32'(cfg_if.cfg_done), 32'(1));
    tick();
    send(2'd0, 8'd2, 1'b1);
    tick();
    tick();
    check("t6_wait_ready", 32'(cfg_if.cfg_ready), 32'(0));
    rst_n = 1'b0;
    tick();
    check("t6_rst_ce", 32'(ce), 32'(0));
    check("t6_rst_clk", 32'(clk_out), 32'(0));
    check("t6_rst_ready", 32'(cfg_if.cfg_ready), 32'(1));
    check("t6_rst_done", 32'(cfg_if.cfg_done), 32'(0));
    check("t6_rst_err", 32'(cfg_if.cfg_err), 32'(0));
    rst_n = 1'b1;
    for (int c = 45; c <= 51; c++) begin
      tick();
      check("t6_post_done", 32'(cfg_if.cfg_done), 32'(0));
      check("t6_post_ce0", 32'(ce[0]), 32'((c - 44) >= 2 && (c - 44) % 2 == 0));
      check("t6_post_ce12", 32'(ce[2:1]), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
